counter_snapshot: RTL and testbench
===================================

COUNTER_SNAPSHOT -- requirements
Module: counter_snapshot

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of event counter channels (1..255).
REQ-002 SHALL have parameter CNT_W, default 32, counter width in bits (8..32).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port addr_in, input, 8, channel select driven by the upstream address PIO out_port.
REQ-006 SHALL have port event_in, input, NUM_CH, per-channel single-cycle event pulses synchronous to clk.
REQ-007 SHALL have port data_out, output, 32, snapshot of the selected counter, zero-extended to 32 bits, for the downstream input PIO.
REQ-008 SHALL have port ovf_out, output, 1, sticky overflow flag of the snapshotted channel.
REQ-009 SHALL have port data_valid, output, 1, high while data_out and ovf_out hold a completed snapshot for the current addr_in.

Function
REQ-010 SHALL keep one CNT_W-bit counter per channel, incremented by 1 on each clk edge where its event_in bit is high.
REQ-011 SHALL wrap a counter from all-ones to 0 and set that channel's sticky overflow bit in the same cycle.
REQ-012 SHALL register addr_in every cycle as addr_q, and detect a change when addr_in differs from addr_q.
REQ-013 SHALL implement FSM states IDLE, SETTLE and SNAP.
REQ-014 SHALL go IDLE->SETTLE on an address change; SETTLE->SNAP if addr_in is unchanged; SETTLE->SETTLE if it changed again; SNAP->IDLE unconditionally.
REQ-015 SHALL deassert data_valid in the cycle after an address change is detected, in every state.
REQ-016 SHALL capture the pre-increment counter value and overflow bit of channel addr_q into data_out/ovf_out on the SNAP edge, and assert data_valid from the next cycle until the next address change.
REQ-017 SHALL therefore produce valid data 3 cycles after a single addr_in change (change edge, SETTLE, SNAP).
REQ-018 SHALL capture data_out = 0 and ovf_out = 0 for addr_q >= NUM_CH with addr_q != 8'hFF.
REQ-019 SHALL treat addr_q == 8'hFF in SNAP as a clear command: zero all counters and overflow bits on that edge, capture data_out = 0 and ovf_out = 0, and assert data_valid.
REQ-020 SHALL let a clear win over a simultaneous event on the same edge (the counter reads 0 afterwards).
REQ-021 SHALL keep counting on all channels, including the selected one, in every FSM state, with no lost events.
REQ-022 SHALL leave data_out/ovf_out unchanged while in IDLE (no live tracking of the counters).

Reset
REQ-023 SHALL, on reset_n low, asynchronously set all counters to 0, all overflow bits to 0, addr_q to 0, FSM to SETTLE, data_out to 0, ovf_out to 0 and data_valid to 0.
REQ-024 SHALL, after reset release, complete a snapshot of channel addr_in without needing an address change (SETTLE->SNAP->IDLE).
REQ-025 SHALL abort an in-progress snapshot on reset with no partial update visible.

Structure
REQ-026 SHALL place the FSM state enumeration and the CLEAR_ADDR constant (8'hFF) in a shared package counter_pkg.
REQ-027 SHALL implement the per-channel counter plus overflow bit as one sub-module, event_counter, instantiated NUM_CH times.

Verification
REQ-028 SHALL cover: reset, addr_in = 3, 5 pulses on event_in[3] -> after addr_in = 3->4->3, data_out = 5, ovf_out = 0, data_valid high 3 cycles after the last change.
REQ-029 SHALL cover: channel 2 preloaded to 32'hFFFF_FFFE, 3 events -> snapshot data_out = 1, ovf_out = 1.
REQ-030 SHALL cover: addr_in = 8'hFF while event_in[0] pulses on the SNAP edge -> a subsequent read of channel 0 gives data_out = 0 and ovf_out = 0.
REQ-031 SHALL cover: addr_in changed on 3 consecutive cycles -> data_valid stays 0 until 2 cycles after the last change settles, with one snapshot of the final channel.
REQ-032 SHALL cover: addr_in = 20 with NUM_CH = 16 -> data_out = 0 and data_valid = 1.
REQ-033 SHALL cover: reset_n pulsed low in SETTLE with 10 prior events on channel 1 -> data_out = 0 and data_valid = 0, then a valid snapshot of 0 after release.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter snapshot block: FSM encoding and
// the reserved channel address that doubles as a clear command.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SNAP   = 2'd2
    } state_e;

    // Selecting this address and letting it settle clears every channel.
    localparam logic [7:0] CLEAR_ADDR = 8'hFF;

    // Width of the downstream input PIO carrying the snapshot.
    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/counter_snapshot_event_counter.sv
// One event channel: a free-running CNT_W-bit counter with a sticky
// overflow flag. A synchronous clear takes priority over an event.
module event_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             event_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next count: clear wins, otherwise increment with wrap and set overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (event_i) begin
            cnt_d = cnt_q + ONE;
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/counter_snapshot.sv
// Bank of event counters read through a PIO pair: the upstream PIO selects
// a channel, the block waits for the address to hold steady for a cycle,
// then latches that channel's count and overflow for the downstream PIO.
module counter_snapshot
    import counter_pkg::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        addr_in,
    input  logic [NUM_CH-1:0] event_in,
    output logic [31:0]       data_out,
    output logic              ovf_out,
    output logic              data_valid
);

    logic [7:0]        addr_q;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;

    logic              addr_change;
    logic              clear_all;
    logic [CNT_W-1:0]  cnt_w [NUM_CH];
    logic              ovf_w [NUM_CH];
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_ovf;

    assign addr_change = (addr_in != addr_q);
    assign clear_all   = (state_q == ST_SNAP) && (addr_q == CLEAR_ADDR);

    genvar g;
    for (g = 0; g < int'(NUM_CH); g++) begin : g_ch
        event_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .clear_i (clear_all),
            .event_i (event_in[g]),
            .cnt_o   (cnt_w[g]),
            .ovf_o   (ovf_w[g])
        );
    end

    // Channel mux; addresses outside the bank (including CLEAR_ADDR) read 0.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr_q == 8'(i)) begin
                sel_cnt = cnt_w[i];
                sel_ovf = ovf_w[i];
            end
        end
    end

    // Next state and snapshot outputs; an address change always drops valid.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (addr_change) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = addr_change ? ST_SETTLE : ST_SNAP;
            end
            ST_SNAP: begin
                state_d = ST_IDLE;
                valid_d = 1'b1;
                if (clear_all) begin
                    data_d = '0;
                    ovf_d  = 1'b0;
                end else begin
                    data_d = DATA_W'(sel_cnt);
                    ovf_d  = sel_ovf;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
        if (addr_change) begin
            valid_d = 1'b0;
        end
    end

    // Address history, FSM state and snapshot registers; reset lands in
    // SETTLE so the reset-time address is read without needing a change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            state_q <= ST_SETTLE;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_in;
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign ovf_out    = ovf_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_counter_snapshot.sv
// Directed and randomized checks of counter_snapshot against a
// countdown-based reference model of the snapshot protocol.
module tb_counter_snapshot;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  addr_in;
    logic [15:0] event_in;
    logic [31:0] data_out;
    logic        ovf_out;
    logic        data_valid;

    logic [7:0]  addr8;
    logic [3:0]  ev8;
    logic [31:0] data8;
    logic        ovf8;
    logic        valid8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_snapshot #(.NUM_CH(16), .CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr_in    (addr_in),
        .event_in   (event_in),
        .data_out   (data_out),
        .ovf_out    (ovf_out),
        .data_valid (data_valid)
    );

    // Narrow instance so counter wrap can be reached with real events.
    counter_snapshot #(.NUM_CH(4), .CNT_W(8)) dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr_in    (addr8),
        .event_in   (ev8),
        .data_out   (data8),
        .ovf_out    (ovf8),
        .data_valid (valid8)
    );

    // Reference model: counts as integers, and a countdown of quiet edges
    // remaining before the snapshot (-1 = nothing pending).
    longint unsigned m_cnt [16];
    bit              m_ovfb [16];
    logic [7:0]      m_addr;
    int              m_wait;
    logic [31:0]     m_data;
    logic            m_ovf;
    logic            m_valid;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_cnt[i]  = 0;
            m_ovfb[i] = 1'b0;
        end
        m_addr  = 8'h00;
        m_wait  = 1;
        m_data  = 32'h0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_edge(input logic [7:0] a, input logic [15:0] ev);
        bit change;
        bit clr;
        int idx;
        change = (a != m_addr);
        clr    = 1'b0;
        idx    = int'(m_addr);
        if (m_wait == 0) begin
            if (m_addr == 8'hFF) begin
                m_data = 32'h0;
                m_ovf  = 1'b0;
                clr    = 1'b1;
            end else if (idx < 16) begin
                m_data = m_cnt[idx][31:0];
                m_ovf  = m_ovfb[idx];
            end else begin
                m_data = 32'h0;
                m_ovf  = 1'b0;
            end
            m_valid = 1'b1;
            m_wait  = -1;
        end else if (m_wait == 1) begin
            m_wait = change ? 1 : 0;
        end else if (change) begin
            m_wait = 1;
        end
        if (change) m_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (clr) begin
                m_cnt[i]  = 0;
                m_ovfb[i] = 1'b0;
            end else if (ev[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == 64'h1_0000_0000) begin
                    m_cnt[i]  = 0;
                    m_ovfb[i] = 1'b1;
                end
            end
        end
        m_addr = a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check at negedge.
    task automatic step(input logic [7:0] a, input logic [15:0] ev);
        addr_in  = a;
        event_in = ev;
        @(posedge clk);
        model_edge(a, ev);
        @(negedge clk);
        chk("model_data", data_out, m_data);
        chk("model_ovf", {31'h0, ovf_out}, {31'h0, m_ovf});
        chk("model_valid", {31'h0, data_valid}, {31'h0, m_valid});
    endtask

    task automatic do_reset(input logic [7:0] a);
        reset_n  = 1'b0;
        addr_in  = a;
        event_in = '0;
        #1;
        chk("rst_data", data_out, 32'h0);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pool [9];
        logic [7:0] ra;
        pool = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd16, 8'd20, 8'd200};

        reset_n = 1'b0; addr_in = '0; event_in = '0; addr8 = '0; ev8 = '0;
        @(negedge clk);
        chk("rst_ovf", {31'h0, ovf_out}, 32'h0);
        chk("rst8_valid", {31'h0, valid8}, 32'h0);
        chk("rst8_data", data8, 32'h0);
        do_reset(8'd0);

        // Snapshot of the reset-time address with no change.
        step(8'd0, '0);
        chk("boot_valid_early", {31'h0, data_valid}, 32'h0);
        step(8'd0, '0);
        chk("boot_valid", {31'h0, data_valid}, 32'h1);

        // Five events on channel 3, then 3->4->3.
        do_reset(8'd3);
        for (int i = 0; i < 5; i++) step(8'd3, 16'h0008);
        for (int i = 0; i < 4; i++) step(8'd3, 16'h0001);
        step(8'd4, '0);
        step(8'd3, '0);
        chk("ch3_valid_c1", {31'h0, data_valid}, 32'h0);
        step(8'd3, '0);
        chk("ch3_valid_c2", {31'h0, data_valid}, 32'h0);
        step(8'd3, '0);
        chk("ch3_data", data_out, 32'd5);
        chk("ch3_ovf", {31'h0, ovf_out}, 32'h0);
        chk("ch3_valid", {31'h0, data_valid}, 32'h1);

        // Clear command with a coincident event on channel 0.
        step(8'hFF, '0);
        step(8'hFF, '0);
        step(8'hFF, 16'h0001);
        chk("clr_data", data_out, 32'h0);
        chk("clr_valid", {31'h0, data_valid}, 32'h1);
        step(8'd0, '0);
        step(8'd0, '0);
        step(8'd0, '0);
        chk("clr_ch0_data", data_out, 32'h0);
        chk("clr_ch0_ovf", {31'h0, ovf_out}, 32'h0);
        chk("clr_ch0_valid", {31'h0, data_valid}, 32'h1);

        // Three back-to-back address changes.
        step(8'd5, 16'h0020);
        step(8'd6, '0);
        step(8'd7, 16'h0080);
        step(8'd7, '0);
        chk("burst_valid_settle", {31'h0, data_valid}, 32'h0);
        step(8'd7, '0);
        chk("burst_valid", {31'h0, data_valid}, 32'h1);
        chk("burst_data", data_out, 32'd1);

        // Out-of-range channel.
        for (int i = 0; i < 3; i++) step(8'd20, '0);
        chk("oor_data", data_out, 32'h0);
        chk("oor_valid", {31'h0, data_valid}, 32'h1);

        // Wrap on the 8-bit instance: 254 events, read, 3 more, read again.
        ev8 = 4'b0100;
        for (int i = 0; i < 254; i++) step(8'd20, '0);
        ev8   = '0;
        addr8 = 8'd2;
        for (int i = 0; i < 3; i++) step(8'd20, '0);
        chk("wrap_pre_data", data8, 32'h0000_00FE);
        chk("wrap_pre_ovf", {31'h0, ovf8}, 32'h0);
        chk("wrap_pre_valid", {31'h0, valid8}, 32'h1);
        ev8 = 4'b0100;
        for (int i = 0; i < 3; i++) step(8'd20, '0);
        ev8   = '0;
        addr8 = 8'd0;
        step(8'd20, '0);
        addr8 = 8'd2;
        for (int i = 0; i < 3; i++) step(8'd20, '0);
        chk("wrap_data", data8, 32'h0000_0001);
        chk("wrap_ovf", {31'h0, ovf8}, 32'h1);
        chk("wrap_valid", {31'h0, valid8}, 32'h1);

        // Reset while SETTLE, after ten events on channel 1.
        step(8'd1, '0);
        for (int i = 0; i < 10; i++) step(8'd1, 16'h0002);
        chk("pre_rst_data", data_out, 32'd1);
        step(8'd2, '0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_valid", {31'h0, data_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(8'd1, '0);
        chk("post_rst_data", data_out, 32'h0);
        chk("post_rst_valid", {31'h0, data_valid}, 32'h1);

        // Randomized traffic against the model.
        ra = 8'd0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 19) == 0) ra = 8'hFF;
                else ra = pool[$urandom_range(0, 8)];
            end
            step(ra, 16'($urandom) & 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
